// File: rtl/glb_packet_streamer_if.sv
// GLB read port and GIN packet handshake bundle.
// master drives SRAM requests and packets; slave is the SRAM/GIN side.
interface glb_packet_streamer_if #(
  parameter int BITWIDTH        = 16,
  parameter int TAG_LENGTH      = 4,
  parameter int GLB_ADDR_LENGTH = 3,
  parameter int PACKET_LENGTH   = 2*TAG_LENGTH+BITWIDTH
);
  logic [GLB_ADDR_LENGTH-1:0] glb_addr;
  logic                       glb_cs;
  logic                       glb_oe;
  logic                       glb_we;
  logic [BITWIDTH-1:0]        glb_rdata;
  logic                       gin_enable;
  logic                       gin_ready;
  logic [PACKET_LENGTH-1:0]   data_packet;

  modport master (
    output glb_addr, glb_cs, glb_oe, glb_we,
    input  glb_rdata,
    output gin_enable, data_packet,
    input  gin_ready
  );

  modport slave (
    input  glb_addr, glb_cs, glb_oe, glb_we,
    output glb_rdata,
    input  gin_enable, data_packet,
    output gin_ready
  );
endinterface

// File: rtl/glb_packet_streamer.sv
// Reads a run of GLB words, tags each with row/col tags
// and streams them to a GIN under a valid/ready handshake.
module glb_packet_streamer #(
  parameter int BITWIDTH        = 16,
  parameter int TAG_LENGTH      = 4,
  parameter int GLB_ADDR_LENGTH = 3,
  parameter int PACKET_LENGTH   = 2*TAG_LENGTH+BITWIDTH
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       start,
  input  logic [GLB_ADDR_LENGTH-1:0] base_addr,
  input  logic [GLB_ADDR_LENGTH:0]   length,
  input  logic [TAG_LENGTH-1:0]      row_tag_init,
  input  logic [TAG_LENGTH-1:0]      col_tag_init,
  input  logic [TAG_LENGTH-1:0]      col_count,
  output logic                       busy,
  output logic                       done,
  glb_packet_streamer_if.master      bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, CAPT, SEND, DONE
  } state_e;

  localparam int AW = GLB_ADDR_LENGTH;
  localparam int TW = TAG_LENGTH;

  state_e state_q, state_d;

  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [TW-1:0] row_q, row_d;
  logic [TW-1:0] col_q, col_d;
  logic [TW-1:0] idx_q, idx_d;
  logic [TW-1:0] coli_q, coli_d;
  logic [TW-1:0] cc_q, cc_d;

  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     cs_q, cs_d;
  logic                     gin_q, gin_d;
  logic [AW-1:0]            gaddr_q, gaddr_d;
  logic [PACKET_LENGTH-1:0] pkt_q, pkt_d;

  logic launch;
  logic xfer;
  logic row_wrap;

  assign launch   = (state_q == IDLE) && start;
  assign xfer     = (state_q == SEND) && bus.gin_ready;
  assign row_wrap = (cc_q != '0) && (idx_q == cc_q - TW'(1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (length == '0) ? DONE : REQ;
      end
      REQ:  state_d = CAPT;
      CAPT: state_d = SEND;
      SEND: begin
        if (bus.gin_ready)
          state_d = (rem_q == (AW+1)'(1)) ? DONE : REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // run context: latched command plus address/count/tag walk
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    row_d  = row_q;
    col_d  = col_q;
    idx_d  = idx_q;
    coli_d = coli_q;
    cc_d   = cc_q;
    unique case (1'b1)
      launch: begin
        addr_d = base_addr;
        rem_d  = length;
        row_d  = row_tag_init;
        col_d  = col_tag_init;
        idx_d  = '0;
        coli_d = col_tag_init;
        cc_d   = col_count;
      end
      xfer: begin
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - (AW+1)'(1);
        if (row_wrap) begin
          idx_d = '0;
          col_d = coli_q;
          row_d = row_q + TW'(1);
        end else begin
          idx_d = idx_q + TW'(1);
          col_d = col_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // run context registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      addr_q <= '0;
      rem_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      idx_q  <= '0;
      coli_q <= '0;
      cc_q   <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      row_q  <= row_d;
      col_q  <= col_d;
      idx_q  <= idx_d;
      coli_q <= coli_d;
      cc_q   <= cc_d;
    end
  end

  // output decode from next state, so every output is a flop
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    cs_d    = (state_d == REQ);
    gin_d   = (state_d == SEND);
    gaddr_d = (state_d == REQ) ? addr_d : gaddr_q;
    pkt_d   = pkt_q;
    if (state_q == CAPT) pkt_d = {row_q, col_q, bus.glb_rdata};
  end

  // output registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      gin_q   <= 1'b0;
      gaddr_q <= '0;
      pkt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      gin_q   <= gin_d;
      gaddr_q <= gaddr_d;
      pkt_q   <= pkt_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.glb_addr    = gaddr_q;
  assign bus.glb_cs      = cs_q;
  assign bus.glb_oe      = cs_q;
  assign bus.glb_we      = 1'b0;
  assign bus.gin_enable  = gin_q;
  assign bus.data_packet = pkt_q;

endmodule

// File: tb/tb_glb_packet_streamer.sv
// Scoreboard bench for glb_packet_streamer.
// GLB model holds word[a] = 0x1000+a.
module tb_glb_packet_streamer;

  logic       clk = 1'b0;
  logic       rstb;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] length;
  logic [3:0] row_tag_init;
  logic [3:0] col_tag_init;
  logic [3:0] col_count;
  logic       busy;
  logic       done;

  glb_packet_streamer_if #(
    .BITWIDTH(16), .TAG_LENGTH(4), .GLB_ADDR_LENGTH(3)
  ) bus_if ();

  glb_packet_streamer #(
    .BITWIDTH(16), .TAG_LENGTH(4), .GLB_ADDR_LENGTH(3)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .row_tag_init (row_tag_init),
    .col_tag_init (col_tag_init),
    .col_count    (col_count),
    .busy         (busy),
    .done         (done),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int c0 = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  logic [23:0] exp_pkt[$];
  logic [2:0]  exp_addr[$];
  int          exp_xcyc[$];

  logic [15:0] mem [8];

  initial for (int a = 0; a < 8; a++) mem[a] = 16'h1000 + 16'(a);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus_if.glb_cs && bus_if.glb_oe)
      bus_if.glb_rdata <= mem[bus_if.glb_addr];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM request and packet transfer monitor
  always @(negedge clk) begin
    if (rstb) begin
      if (bus_if.glb_cs) begin
        if (exp_addr.size() == 0) chk("unexp_cs", 1, 0);
        else chk("addr", 64'(bus_if.glb_addr), 64'(exp_addr.pop_front()));
        chk("oe", 64'(bus_if.glb_oe), 1);
        chk("we", 64'(bus_if.glb_we), 0);
      end
      if (bus_if.gin_enable && bus_if.gin_ready) begin
        xfer_cnt++;
        if (exp_pkt.size() == 0) chk("unexp_pkt", 1, 0);
        else chk("pkt", 64'(bus_if.data_packet), 64'(exp_pkt.pop_front()));
        if (exp_xcyc.size() != 0)
          chk("xfer_cyc", 64'(cyc - c0), 64'(exp_xcyc.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_run(input int b, input int l, input int r,
                           input int c, input int cc);
    int row, col, idx, a;
    row = r; col = c; idx = 0;
    for (int i = 0; i < l; i++) begin
      a = (b + i) % 8;
      exp_addr.push_back(3'(a));
      exp_pkt.push_back({4'(row), 4'(col), 16'(16'h1000 + a)});
      if (cc != 0 && idx == cc - 1) begin
        idx = 0; col = c; row = (row + 1) % 16;
      end else begin
        idx++; col = (col + 1) % 16;
      end
    end
    @(posedge clk); #1;
    base_addr = 3'(b); length = 4'(l);
    row_tag_init = 4'(r); col_tag_init = 4'(c);
    col_count = 4'(cc);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 3'($urandom); length = 4'($urandom);
    row_tag_init = 4'($urandom); col_tag_init = 4'($urandom);
    col_count = 4'($urandom);
  endtask

  task automatic wait_done(output int rel);
    bit seen;
    seen = 0;
    rel = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; rel = cyc - c0; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_idle_after(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_cs"},   64'(bus_if.glb_cs), 0);
    chk({tag, "_oe"},   64'(bus_if.glb_oe), 0);
    chk({tag, "_we"},   64'(bus_if.glb_we), 0);
    chk({tag, "_gen"},  64'(bus_if.gin_enable), 0);
    chk({tag, "_addr"}, 64'(bus_if.glb_addr), 0);
    chk({tag, "_pkt"},  64'(bus_if.data_packet), 0);
  endtask

  initial begin
    int d, n0;
    rstb = 1'b0; start = 1'b0;
    base_addr = '0; length = '0;
    row_tag_init = '0; col_tag_init = '0; col_count = '0;
    bus_if.gin_ready = 1'b1;
    bus_if.glb_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1;
    rstb = 1'b1;

    // basic run
    exp_xcyc.push_back(3); exp_xcyc.push_back(6); exp_xcyc.push_back(9);
    start_run(0, 3, 0, 0, 0);
    wait_done(d);
    chk("basic_done_cyc", 64'(d), 10);
    chk_idle_after("basic");

    // address and tag wrap
    start_run(6, 7, 1, 2, 3);
    wait_done(d);
    chk("wrap_done_cyc", 64'(d), 22);
    chk_idle_after("wrap");

    // backpressure during cycles 3..7
    exp_xcyc.push_back(8); exp_xcyc.push_back(11); exp_xcyc.push_back(14);
    start_run(0, 3, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    bus_if.gin_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_pkt", 64'(bus_if.data_packet), 64'h001000);
      chk("bp_gen", 64'(bus_if.gin_enable), 1);
      chk("bp_cs",  64'(bus_if.glb_cs), 0);
      @(posedge clk); #1;
    end
    bus_if.gin_ready = 1'b1;
    wait_done(d);
    chk("bp_done_cyc", 64'(d), 15);
    chk_idle_after("bp");

    // zero length
    n0 = xfer_cnt;
    start_run(2, 0, 0, 0, 0);
    wait_done(d);
    chk("zero_done_cyc", 64'(d), 1);
    chk_idle_after("zero");
    chk("zero_xfers", 64'(xfer_cnt - n0), 0);

    // start while busy is ignored
    n0 = xfer_cnt;
    start_run(0, 3, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    base_addr = 3'd5; length = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d);
    chk("sib_done_cyc", 64'(d), 10);
    chk_idle_after("sib");
    chk("sib_xfers", 64'(xfer_cnt - n0), 3);

    // reset during SEND drops the packet
    start_run(4, 3, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    bus_if.gin_ready = 1'b0;
    rstb = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midrst");
    exp_pkt.delete();
    exp_addr.delete();
    @(posedge clk); #1;
    rstb = 1'b1;
    bus_if.gin_ready = 1'b1;
    start_run(5, 2, 3, 4, 0);
    wait_done(d);
    chk("postrst_done_cyc", 64'(d), 7);
    chk_idle_after("postrst");

    // full depth
    n0 = done_cnt;
    start_run(3, 8, 0, 0, 0);
    wait_done(d);
    chk("full_done_cyc", 64'(d), 25);
    repeat (4) @(negedge clk);
    chk("full_done_once", 64'(done_cnt - n0), 1);

    chk("pkt_q_empty",  64'(exp_pkt.size()), 0);
    chk("addr_q_empty", 64'(exp_addr.size()), 0);
    chk("xcyc_q_empty", 64'(exp_xcyc.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/glb_packet_streamer.md
# glb_packet_streamer

Upstream feeder for one GIN (ifmap or filter). On a start command it reads a run of words from its GLB single-port SRAM, tags each word with a row/column tag pair, and delivers the result to the GIN as a `data_packet` under the `gin_enable`/`gin_ready` handshake. Two instances sit in the accelerator, one per GIN. Together they replace the test-only external `data_packet_*` / `gin_enable_*` drive.

## Interface

Parameters:
- `BITWIDTH`, 16: data word width.
- `TAG_LENGTH`, 4: width of each of the row and column tags.
- `GLB_ADDR_LENGTH`, 3: GLB address width; depth is 2^GLB_ADDR_LENGTH.
- `PACKET_LENGTH`, 2*TAG_LENGTH+BITWIDTH: packet width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rstb` in 1: reset, synchronous, active-low.
- `start` in 1: command pulse; sampled only in IDLE.
- `base_addr` in GLB_ADDR_LENGTH: first GLB address.
- `length` in GLB_ADDR_LENGTH+1: number of words to send, 0..2^GLB_ADDR_LENGTH.
- `row_tag_init` in TAG_LENGTH: first row tag.
- `col_tag_init` in TAG_LENGTH: first column tag.
- `col_count` in TAG_LENGTH: column tags per row; 0 means never advance the row tag.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last transfer.
- `glb_addr` out GLB_ADDR_LENGTH: SRAM address.
- `glb_cs`, `glb_oe` out 1: SRAM chip select and output enable.
- `glb_we` out 1: tied 0; this block only reads.
- `glb_rdata` in BITWIDTH: SRAM read data, valid the cycle after a request.
- `gin_enable` out 1: packet valid.
- `gin_ready` in 1: GIN can accept a packet.
- `data_packet` out PACKET_LENGTH: `{row_tag, col_tag, data}`. Row tag in the MSBs, data in bits [BITWIDTH-1:0].

## Operation

- FSM states: IDLE, REQ, CAPT, SEND, DONE.
- IDLE + `start`:
  - Latch `base_addr`, `length`, both tag inits and `col_count` into internal registers. Inputs are don't-care afterwards.
  - Go to REQ, or to DONE if `length`==0.
- REQ:
  - `glb_cs`=`glb_oe`=1; `glb_addr` = current address.
  - Next state CAPT.
- CAPT:
  - Register `{row_tag, col_tag, glb_rdata}` into `data_packet`.
  - Next state SEND.
- SEND:
  - `gin_enable`=1.
  - A transfer happens on an edge where `gin_enable` && `gin_ready`.
  - While `gin_ready`=0, `data_packet` and `gin_enable` hold stable and no SRAM access is made.
  - On transfer: decrement remaining count, address +1, advance tags. Next state is DONE if remaining was 1, else REQ.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic: address increments modulo 2^GLB_ADDR_LENGTH (wraps 7→0 at default size).
- Tag arithmetic:
  - A column index counts 0..`col_count`-1; col_tag = `col_tag_init` + index, mod 2^TAG_LENGTH.
  - When the index wraps, it returns to 0 and row_tag increments mod 2^TAG_LENGTH.
  - With `col_count`=0, col_tag increments mod 2^TAG_LENGTH every packet and row_tag stays constant.
- `start` outside IDLE, including during DONE, is ignored.
- `rstb`=0 at an edge: FSM to IDLE and all outputs to 0 at that edge, even mid-transfer. The packet in flight is dropped.

## Timing

- Reset values: `busy`, `done`, `glb_cs`, `glb_oe`, `glb_we`, `gin_enable` = 0; `glb_addr` = 0; `data_packet` = 0.
- `start` sampled at the edge ending cycle 0:
  - cycle 1: REQ;
  - cycle 2: CAPT;
  - cycle 3: SEND.
- First-packet latency is 3 cycles after `start`. With `gin_ready` held high, throughput is one packet per 3 cycles.
- After the last transfer at the end of cycle t: `done`=1 and `busy`=1 in cycle t+1; IDLE in t+2. The earliest new `start` is sampled in t+2.
- `length`=0: DONE in cycle 1, IDLE in cycle 2. No SRAM or GIN activity.
- All outputs are registered, with no combinational path from `gin_ready` to any output.

## Test plan

GLB is preloaded with word[a] = 0x1000+a. Packets are shown as hex with TAG_LENGTH=4.

- **Basic run.** base 0, length 3, tags 0/0, col_count 0, `gin_ready`=1.
  - Packets 0x001000, 0x011001, 0x021002.
  - `gin_enable` high in cycles 3, 6, 9; `done` in cycle 10; `busy` low in cycle 11.
- **Address and tag wrap.** base 6, length 7, row_init 1, col_init 2, col_count 3.
  - Addresses 6,7,0,1,2,3,4.
  - Tags (1,2),(1,3),(1,4),(2,2),(2,3),(2,4),(3,2).
  - First packet 0x121006; third packet 0x141000.
- **Backpressure.** `gin_ready`=0 for cycles 3–7 of the basic run.
  - `data_packet` holds 0x001000 and `gin_enable` stays high; `glb_cs`=0 throughout.
  - Transfer at cycle 8; next REQ at cycle 9; `done` at cycle 15.
- **Zero length.** `length`=0: `done` in cycle 1, `busy` low in cycle 2, no `glb_cs`, no `gin_enable`.
- **Start while busy, then reset.** A `start` pulse in cycle 4 of a length-3 run is ignored: still exactly 3 packets.
  - `rstb`=0 in a SEND cycle: next cycle all outputs are 0 and the FSM is in IDLE.
  - A new `start` after reset runs normally from its `base_addr`.
- **Full depth.** base 3, length 8, col_count 0: 8 packets with addresses 3..7,0,1,2 and col tags 0..7; `done` once.
